// File: rtl/clock_disp_pkg.sv
// rtl/clock_disp_pkg.sv - shared digit codes, segment patterns and scan state type for the clock display
package clock_disp_pkg;

    localparam int NUM_DIGITS = 6;
    localparam int IDX_W      = 3;

    localparam logic [3:0] BLANK_CODE = 4'hF;

    // Segment order is a..g, with a at index 0
    localparam logic [0:6] SEG_0    = 7'b1111110;
    localparam logic [0:6] SEG_1    = 7'b0110000;
    localparam logic [0:6] SEG_2    = 7'b1101101;
    localparam logic [0:6] SEG_3    = 7'b1111001;
    localparam logic [0:6] SEG_4    = 7'b0110011;
    localparam logic [0:6] SEG_5    = 7'b1011011;
    localparam logic [0:6] SEG_6    = 7'b0011111;
    localparam logic [0:6] SEG_7    = 7'b1110000;
    localparam logic [0:6] SEG_8    = 7'b1111111;
    localparam logic [0:6] SEG_9    = 7'b1110011;
    localparam logic [0:6] SEG_DASH = 7'b0000001;
    localparam logic [0:6] SEG_OFF  = 7'b0000000;

    typedef enum logic {
        DEAD  = 1'b0,
        DRIVE = 1'b1
    } scan_state_e;

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - combinational 4-bit digit code to a..g segment decoder
module seg7_decode
    import clock_disp_pkg::*;
(
    input  logic [3:0] code_i,
    output logic [0:6] seg_o
);

    // Codes A..E are never produced by a healthy time counter, so show a dash
    always_comb begin
        seg_o = SEG_OFF;
        case (code_i)
            4'h0: seg_o = SEG_0;
            4'h1: seg_o = SEG_1;
            4'h2: seg_o = SEG_2;
            4'h3: seg_o = SEG_3;
            4'h4: seg_o = SEG_4;
            4'h5: seg_o = SEG_5;
            4'h6: seg_o = SEG_6;
            4'h7: seg_o = SEG_7;
            4'h8: seg_o = SEG_8;
            4'h9: seg_o = SEG_9;
            4'hA, 4'hB, 4'hC, 4'hD, 4'hE: seg_o = SEG_DASH;
            default: seg_o = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/six_digit_scan_driver.sv
// rtl/six_digit_scan_driver.sv - double-buffered six-digit multiplexed 7-segment driver; LEAD_ZERO_BLANK_EN blanks a leading hours zero
module six_digit_scan_driver #(
    parameter int SCAN_DIV   = 1000,
    parameter int DEAD_CYC   = 50,
    parameter int NUM_DIGITS = 6
) (
    input  logic                    sing_clk,
    input  logic                    clr,
    input  logic                    upd_valid,
    input  logic [4*NUM_DIGITS-1:0] upd_data,
    output logic                    upd_ready,
    output logic [0:6]              seg,
    output logic [NUM_DIGITS-1:0]   dig_n,
    output logic                    frame_start
);
    import clock_disp_pkg::*;

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'((DEAD_CYC > 0) ? DEAD_CYC - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    scan_state_e                     state_q, state_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic [IDX_W-1:0]                idx_q, idx_d;
    logic [NUM_DIGITS-1:0][3:0]      active_q, active_d;
    logic [NUM_DIGITS-1:0][3:0]      pend_q, pend_d;
    logic                            pend_flag_q, pend_flag_d;
    logic                            frame_start_q, frame_start_d;

    logic                            slot_end;
    logic                            frame_wrap;
    logic                            accept;
    logic [3:0]                      shown_code;
    logic [0:6]                      dec_seg;
    logic [NUM_DIGITS-1:0]           sel_onehot;

    assign slot_end   = (cnt_q == CNT_LAST);
    assign frame_wrap = slot_end && (idx_q == IDX_LAST);
    assign accept     = upd_valid && !pend_flag_q;

    always_comb begin
        cnt_d         = slot_end ? '0 : cnt_q + 1'b1;
        idx_d         = idx_q;
        state_d       = state_q;
        active_d      = active_q;
        pend_d        = pend_q;
        pend_flag_d   = pend_flag_q;
        frame_start_d = frame_wrap;

        if (slot_end) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end

        // With no dead time the DEAD state only exists for the first cycle out of reset
        case (state_q)
            DEAD: begin
                if ((DEAD_CYC == 0) || (cnt_q == DEAD_LAST)) begin
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                if (slot_end && (DEAD_CYC != 0)) begin
                    state_d = DEAD;
                end
            end
            default: state_d = DEAD;
        endcase

        // Swap only on the frame boundary so a frame is never shown half old, half new
        if (frame_wrap && pend_flag_q) begin
            active_d    = pend_q;
            pend_flag_d = 1'b0;
        end

        if (accept) begin
            pend_d      = upd_data;
            pend_flag_d = 1'b1;
        end
    end

    always_ff @(posedge sing_clk or negedge clr) begin
        if (!clr) begin
            state_q       <= DEAD;
            cnt_q         <= '0;
            idx_q         <= '0;
            active_q      <= {NUM_DIGITS{BLANK_CODE}};
            pend_q        <= {NUM_DIGITS{BLANK_CODE}};
            pend_flag_q   <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            active_q      <= active_d;
            pend_q        <= pend_d;
            pend_flag_q   <= pend_flag_d;
            frame_start_q <= frame_start_d;
        end
    end

`ifdef LEAD_ZERO_BLANK_EN
    always_comb begin
        shown_code = active_q[idx_q];
        if ((idx_q == IDX_LAST) && (active_q[idx_q] == 4'h0)) begin
            shown_code = BLANK_CODE;
        end
    end
`else
    always_comb begin
        shown_code = active_q[idx_q];
    end
`endif

    seg7_decode u_decode (
        .code_i (shown_code),
        .seg_o  (dec_seg)
    );

    assign sel_onehot  = NUM_DIGITS'(1) << idx_q;
    assign seg         = (state_q == DRIVE) ? dec_seg : SEG_OFF;
    assign dig_n       = (state_q == DRIVE) ? ~sel_onehot : '1;
    assign upd_ready   = ~pend_flag_q;
    assign frame_start = frame_start_q;

endmodule

// File: doc/six_digit_scan_driver.md
Name: six_digit_scan_driver

Overview:
- Receiving end of the clock's digit bus: takes six 4-bit digit codes (seconds units … hours tens; code 4'hF = blank/flash-off) and drives one shared, time-multiplexed common-cathode 7-segment bus.
- Double-buffers each update so that a frame is never torn.
- Inserts a dead time between digits to suppress ghosting.
- Runs on sing_clk, alongside the alarm/speaker logic.

Parameters:
- SCAN_DIV, 1000: sing_clk cycles per digit slot. Must be >= 2.
- DEAD_CYC, 50: cycles at the start of each slot with all digits off. Must be < SCAN_DIV.
- NUM_DIGITS, 6: fixed digit count. Not intended to be overridden.

Ports:
- sing_clk, in, 1: scan clock.
- clr, in, 1: reset, asynchronous, active-low.
- upd_valid, in, 1: upd_data holds a new frame.
- upd_data, in, 24: digit k at bits [4k+3:4k]; k=0 is seconds units, k=5 is hours tens.
- upd_ready, out, 1: pending buffer empty; a transfer happens when upd_valid and upd_ready are both high on a clock edge.
- seg, out, [0:6]: segments a..g, active-high.
- dig_n, out, 6: digit enables, one-hot active-low; bit k selects digit k.
- frame_start, out, 1: one-cycle pulse on the first cycle of digit 0's slot.

Behaviour:
- Reset (clr low, async):
  - state DEAD, idx=0, cnt=0.
  - active buffer all 4'hF; pending buffer all 4'hF; pend_flag=0.
  - frame_start=0; seg=0000000; dig_n=111111; upd_ready=1.
- Counters:
  - cnt counts 0..SCAN_DIV-1, width $clog2(SCAN_DIV).
  - When cnt=SCAN_DIV-1, cnt wraps to 0 and idx advances (idx=5 wraps to 0). That edge is the "frame wrap" only when idx goes 5→0.
- State machine, two states:
  - DEAD: covers cnt < DEAD_CYC. dig_n=111111, seg=0.
  - DRIVE: covers cnt >= DEAD_CYC. dig_n bit idx low, seg = decode(active[idx]).
  - DEAD→DRIVE at cnt=DEAD_CYC-1. With DEAD_CYC=0, DEAD is never entered except out of reset.
  - DRIVE→DEAD at cnt=SCAN_DIV-1.
- Handshake:
  - upd_ready = ~pend_flag.
  - On an accepting edge: pending <= upd_data, pend_flag <= 1.
- Frame wrap edge:
  - If pend_flag: active <= pending, pend_flag <= 0.
  - frame_start is high for the following cycle.
  - upd_valid arriving on that same edge while pend_flag=1 is not accepted (upd_ready is low). It is accepted next cycle and shown one frame later.
- Latency: an accepted update appears at the next frame wrap, so worst case 6*SCAN_DIV cycles plus 1.
- No frame_start after reset until the first wrap.
- The active buffer changes only at frame wraps; upd_data changing mid-frame has no visible effect.
- Decode table (seg a..g):
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=0011111, 7=1110000, 8=1111111, 9=1110011
  - 4'hA–4'hE = 0000001 (dash, error indicator)
  - 4'hF = 0000000
- Outputs are decoded only from registered state, idx and the active buffer. There is no combinational path from upd_* to seg/dig_n.
- Reset mid-frame: outputs go dark immediately, all buffers return to blank, and any pending update is lost.

Optional Feature:
- Macro LEAD_ZERO_BLANK_EN.
- Defined: digit 5 (hours tens) with code 4'h0 is displayed as blank (seg=0, dig_n bit 5 still low in DRIVE).
- Undefined: digit 5 code 4'h0 displays "0" (1111110).

Decomposition:
- Package clock_disp_pkg holds:
  - NUM_DIGITS and BLANK_CODE=4'hF.
  - SEG_0..SEG_9, SEG_DASH, SEG_OFF as 7-bit constants.
  - A typedef for the scan state enum {DEAD, DRIVE}.
- One sub-module: seg7_decode, purely combinational, 4-bit code → [0:6] segments using the package constants. The clock top and this driver both use it.

Test Plan (bench uses SCAN_DIV=8, DEAD_CYC=2; one frame is 48 cycles):
- Reset then idle 100 cycles → seg=0 throughout; dig_n is 111111 in DEAD cycles, and in DRIVE has exactly one low bit cycling 0..5 with a 6-cycle low width; first frame_start at cycle 48.
- upd_data=24'h235959 with a valid pulse at cycle 10 → accepted (upd_ready falls); at the first frame wrap the slots show 9,5,9,5,3,2 (digit 0 seg=1110011, digit 5 seg=1101101); upd_ready rises.
- Two back-to-back valids, 24'h000001 then 24'h111111 → the second stalls while upd_ready=0; frame N shows 000001, frame N+1 shows 111111.
- Digit code 4'hF in slot 2 and 4'hC in slot 3 → slot 2 seg=0000000, slot 3 seg=0000001.
- clr pulsed low mid-DRIVE of digit 3 → same cycle dig_n=111111 and seg=0; after release the display stays blank until a new update and a frame wrap.
- Hours tens = 0 → seg=0000000 with LEAD_ZERO_BLANK_EN defined, 1111110 without.
